mac_ctrl: RTL and testbench
===========================

MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, 4, result FIFO entries (power of two, >=2).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle job start pulse; honoured only in IDLE.
REQ-005 num_groups / wgt_per_pix  in  8 each  pixel groups per job / weights per group, latched at start.
REQ-006 busy / done  out  1 each  high outside IDLE / one-cycle job-complete pulse.
REQ-007 pix_in, pix_valid, pix_ready  in/in/out  128/1/1  packed 8x16-bit pixel group stream, lane k = bits [16k+15:16k].
REQ-008 wgt_in, wgt_valid, wgt_ready  in/in/out  128/1/1  packed 8x16-bit weight vector stream, same lane order.
REQ-009 mac_enable, mac_update_inputs  out  1 each  MAC pipeline advance / pixel load strobe.
REQ-010 mac_pix, mac_wgt  out  128 each  pass-through of pix_in / wgt_in to MAC lanes 0..7.
REQ-011 mac_res  in  16  MAC registered sum output.
REQ-012 res_out, res_valid, res_ready  out/out/in  16/1/1  result stream (FIFO head).
REQ-013 stall_cycles  out  16  stall counter (see Configuration).

Function
REQ-014 Transfer on any stream occurs on an edge where valid and ready are both high; data SHALL be held by producer until transfer.
REQ-015 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start with both counts nonzero; IDLE->DONE on start with either count zero (no issue).
REQ-016 Tag shift register v[2:0] mirrors MAC stages (weight regs, product regs, sum reg); shifts only on edges where mac_enable=1; v[0] loads 1 on issue, else 0.
REQ-017 can_push = ~fifo_full | res_ready; mac_enable = ~(v[2] & ~can_push), forced 0 while rst high.
REQ-018 Issue (RUN only) when mac_enable & wgt_valid & (wcnt!=0 | pix_valid): wgt_ready=1; if wcnt==0 also pix_ready=1 and mac_update_inputs=1, same cycle.
REQ-019 pix_ready/wgt_ready/mac_update_inputs SHALL be 0 whenever no issue occurs; non-issue cycles with mac_enable=1 are bubbles (v[0]=0).
REQ-020 wcnt increments per issue, wraps to 0 at wgt_per_pix-1 and increments group count; issue of final weight of final group -> DRAIN.
REQ-021 When v[2]=1 and can_push, mac_res SHALL be pushed into FIFO on that edge; each tagged result pushed exactly once, in issue order.
REQ-022 Latency: weight accepted at edge E0 with no stall -> res_valid high after edge E3.
REQ-023 FIFO simultaneous push and pop when full SHALL succeed; pop on empty impossible (res_valid=0).
REQ-024 DRAIN->DONE when v==0 and FIFO empty; DONE lasts one cycle (done=1) -> IDLE.
REQ-025 start outside IDLE SHALL be ignored; counts latched only at accepted start.
REQ-026 Results are raw mac_res; no arithmetic performed by this block.

Reset
REQ-027 rst SHALL immediately clear FSM to IDLE, v, counters, FIFO, stall_cycles; outputs busy, done, ready signals, res_valid, mac_update_inputs, mac_enable = 0.
REQ-028 Reset mid-job abandons all in-flight and queued results; no done pulse.

Configuration
REQ-029 Macro MAC_CTRL_STALL_CNT_EN defined: stall_cycles counts cycles with busy=1 and mac_enable=0, saturating at 16'hFFFF, cleared on accepted start.
REQ-030 Macro undefined: stall_cycles tied to 0, counter logic absent; all other behaviour identical.

Verification
REQ-031 num_groups=1, wgt_per_pix=1, all valid, res_ready=1 -> one update_inputs pulse, res_valid after E3, res_out = sum of (pix*wgt)[23:8] lanes, done 1 cycle after pop.
REQ-032 num_groups=2, wgt_per_pix=3 -> exactly 2 pix transfers, 6 weight transfers, 6 results in order, update_inputs on weights 0 and 3 only.
REQ-033 res_ready=0 with 8 weights, FIFO_DEPTH=4 -> 4 entries queued, mac_enable low with v[2]=1, no result lost; release -> 8 results in order, stall_cycles nonzero (macro on).
REQ-034 wgt_valid toggling 1/0 each cycle -> bubbles not pushed; result count equals weight transfers.
REQ-035 start with num_groups=0 -> no ready asserted, done pulse 2 cycles after start.
REQ-036 rst asserted mid-RUN with results queued -> res_valid, busy drop immediately; next start runs cleanly.

Source files
------------

// File: rtl/mac_ctrl.sv
// Sequencer for an 8-lane MAC pipeline: streams pixel groups and weights in, tags
// results through the pipeline, and queues them in a small result FIFO.
// Optional stall counter enabled by defining MAC_CTRL_STALL_CNT_EN.
module mac_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   num_groups,
  input  logic [7:0]   wgt_per_pix,
  output logic         busy,
  output logic         done,
  input  logic [127:0] pix_in,
  input  logic         pix_valid,
  output logic         pix_ready,
  input  logic [127:0] wgt_in,
  input  logic         wgt_valid,
  output logic         wgt_ready,
  output logic         mac_enable,
  output logic         mac_update_inputs,
  output logic [127:0] mac_pix,
  output logic [127:0] mac_wgt,
  input  logic [15:0]  mac_res,
  output logic [15:0]  res_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [15:0]  stall_cycles
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    v_q, v_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic [7:0]    gcnt_q, gcnt_d;
  logic [7:0]    ng_q, ng_d;
  logic [7:0]    wpp_q, wpp_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   mem_q [FIFO_DEPTH];

  logic fifo_full_s, fifo_empty_s, can_push_s, issue_s, push_s, pop_s;

  // The pipeline only stalls when a tagged result reaches the end with nowhere to go.
  assign fifo_full_s  = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty_s = (cnt_q == '0);
  assign can_push_s   = ~fifo_full_s | res_ready;
  assign mac_enable   = ~(v_q[2] & ~can_push_s) & ~rst;
  assign issue_s      = (state_q == S_RUN) & mac_enable & wgt_valid &
                        ((wcnt_q != 8'd0) | pix_valid);
  assign push_s       = v_q[2] & can_push_s;
  assign pop_s        = ~fifo_empty_s & res_ready;

  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign wgt_ready         = issue_s;
  assign pix_ready         = issue_s & (wcnt_q == 8'd0);
  assign mac_update_inputs = issue_s & (wcnt_q == 8'd0);
  assign mac_pix           = pix_in;
  assign mac_wgt           = wgt_in;
  assign res_valid         = ~fifo_empty_s;
  assign res_out           = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    gcnt_d   = gcnt_q;
    ng_d     = ng_q;
    wpp_d    = wpp_q;
    v_d      = mac_enable ? {v_q[1:0], issue_s} : v_q;
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push_s) - CW'(pop_s);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ng_d   = num_groups;
          wpp_d  = wgt_per_pix;
          wcnt_d = 8'd0;
          gcnt_d = 8'd0;
          if ((num_groups != 8'd0) && (wgt_per_pix != 8'd0)) state_d = S_RUN;
          else                                               state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (issue_s) begin
          if (wcnt_q == wpp_q - 8'd1) begin
            wcnt_d = 8'd0;
            if (gcnt_q == ng_q - 8'd1) begin
              gcnt_d  = 8'd0;
              state_d = S_DRAIN;
            end else begin
              gcnt_d = gcnt_q + 8'd1;
            end
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      S_DRAIN: begin
        if ((v_q == 3'b000) && fifo_empty_s) state_d = S_DONE;
        else                                 state_d = S_DRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      v_q      <= 3'b000;
      wcnt_q   <= 8'd0;
      gcnt_q   <= 8'd0;
      ng_q     <= 8'd0;
      wpp_q    <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      wcnt_q   <= wcnt_d;
      gcnt_q   <= gcnt_d;
      ng_q     <= ng_d;
      wpp_q    <= wpp_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Result storage; a push into a full FIFO is only possible alongside a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 16'd0;
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= mac_res;
    end
  end

`ifdef MAC_CTRL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start)                        stall_d = 16'd0;
    else if (busy && ~mac_enable && (stall_q != 16'hFFFF))   stall_d = stall_q + 16'd1;
    else                                                     stall_d = stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= 16'd0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_mac_ctrl.sv
// Randomised scoreboard bench for mac_ctrl with a behavioural 3-stage MAC model.
module tb_mac_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   num_groups, wgt_per_pix;
  logic         busy, done;
  logic [127:0] pix_in, wgt_in;
  logic         pix_valid, pix_ready, wgt_valid, wgt_ready;
  logic         mac_enable, mac_update_inputs;
  logic [127:0] mac_pix, mac_wgt;
  logic [15:0]  mac_res;
  logic [15:0]  res_out;
  logic         res_valid, res_ready;
  logic [15:0]  stall_cycles;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  mac_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_groups(num_groups), .wgt_per_pix(wgt_per_pix),
    .busy(busy), .done(done), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .wgt_in(wgt_in), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .mac_enable(mac_enable),
    .mac_update_inputs(mac_update_inputs), .mac_pix(mac_pix), .mac_wgt(mac_wgt),
    .mac_res(mac_res), .res_out(res_out), .res_valid(res_valid), .res_ready(res_ready),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lane_sum(input logic [127:0] p, input logic [127:0] w);
    logic [15:0] s;
    logic [31:0] pr;
    s = 16'd0;
    for (int k = 0; k < 8; k++) begin
      pr = p[16*k +: 16] * w[16*k +: 16];
      s  = s + pr[23:8];
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural MAC: pixel register, products, registered sum; advances on mac_enable.
  logic [127:0] mp_r;
  logic [15:0]  s0_r, s1_r;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mp_r <= '0; s0_r <= '0; s1_r <= '0; mac_res <= '0;
    end else if (mac_enable) begin
      if (mac_update_inputs) mp_r <= mac_pix;
      s0_r    <= lane_sum(mac_update_inputs ? mac_pix : mp_r, mac_wgt);
      s1_r    <= s0_r;
      mac_res <= s1_r;
    end
  end

  // Result monitor: pops the scoreboard on every accepted result.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got %0h, expected no result", res_out);
        end else begin
          e = exp_q.pop_front();
          chk("result_data", 32'(res_out), 32'(e));
        end
      end
    end
  end

  task automatic recover();
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b0;
  endtask

  // wmode: 0 always valid, 1 toggling, 2 random; rmode: 0 ready, 1 random, 2 low until cycle 30
  task automatic run_job(input int ng, input int wpp, input int wmode, input int rmode,
                         input int abort_at, input bit lat_chk);
    logic [127:0] pg[$];
    logic [127:0] wq[$];
    int total, wi, pi, pix_x, upd_n, c, n0, rv0, done_c;
    bit wv_hold, pv_hold, done_seen, stall_seen;
    total = ng * wpp;
    for (int i = 0; i < ng; i++)    pg.push_back(rnd128());
    for (int i = 0; i < total; i++) wq.push_back(rnd128());
    wi = 0; pi = 0; pix_x = 0; upd_n = 0; c = 0; n0 = -1; rv0 = -1; done_c = -1;
    wv_hold = 1'b0; pv_hold = 1'b0; done_seen = 1'b0; stall_seen = 1'b0;
    wgt_valid = 1'b0; pix_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; num_groups = 8'(ng); wgt_per_pix = 8'(wpp);
    @(posedge clk); #1;
    start = 1'b0; num_groups = 8'($urandom); wgt_per_pix = 8'($urandom);
    while (!done_seen && c < 2000) begin
      start = ($urandom_range(0, 7) == 0);
      if (!wv_hold) begin
        wgt_in = (wi < total) ? wq[wi] : rnd128();
        if (total == 0)       wgt_valid = 1'b1;
        else if (wi >= total) wgt_valid = 1'b0;
        else if (wmode == 0)  wgt_valid = 1'b1;
        else if (wmode == 1)  wgt_valid = ~wgt_valid;
        else                  wgt_valid = 1'($urandom_range(0, 1));
      end
      if (!pv_hold) begin
        pix_in = (pi < ng) ? pg[pi] : rnd128();
        if (total == 0)      pix_valid = 1'b1;
        else if (pi >= ng)   pix_valid = 1'b0;
        else if (wmode == 2) pix_valid = 1'($urandom_range(0, 1));
        else                 pix_valid = 1'b1;
      end
      if (rmode == 0)      res_ready = 1'b1;
      else if (rmode == 1) res_ready = 1'($urandom_range(0, 1));
      else                 res_ready = (c >= 30);
      c++;
      @(negedge clk);
      if (abort_at > 0 && c == abort_at) begin
        chk("abort_results_queued", 32'(res_valid), 32'd1);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_outputs_cleared",
            32'({res_valid, busy, mac_enable, wgt_ready, pix_ready, done}), 32'd0);
        exp_q.delete();
        wgt_valid = 1'b0; pix_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (wgt_valid && wgt_ready) begin
        if (wi < total) begin
          chk("pix_ready_at_group_start", 32'(pix_ready), 32'(wi % wpp == 0));
          chk("mac_wgt_passthru", 32'(mac_wgt == wgt_in), 32'd1);
          exp_q.push_back(lane_sum(pg[wi / wpp], wq[wi]));
          if (n0 < 0) n0 = c;
          wi++;
        end else begin
          chk("unexpected_wgt_transfer", 32'(wi), 32'(total - 1));
        end
      end else begin
        chk("readies_without_issue", 32'({wgt_ready, pix_ready, mac_update_inputs}), 32'd0);
      end
      if (pix_valid && pix_ready) begin
        chk("mac_pix_passthru", 32'(mac_pix == pix_in), 32'd1);
        chk("update_with_pix", 32'(mac_update_inputs), 32'd1);
        pix_x++; pi++;
      end
      if (mac_update_inputs) upd_n++;
      if (res_valid && rv0 < 0) rv0 = c;
      if (busy && !mac_enable && res_valid) stall_seen = 1'b1;
      if (rmode == 2 && total == 8 && c == 25) chk("bp_wgt_transfers", 32'(wi), 32'd7);
      if (done) begin done_seen = 1'b1; done_c = c; end
      wv_hold = wgt_valid && !wgt_ready;
      pv_hold = pix_valid && !pix_ready;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("job_done_seen", 32'(done_seen), 32'd1);
    if (!done_seen) begin
      recover();
      return;
    end
    chk("wgt_transfers", 32'(wi), 32'(total));
    chk("pix_transfers", 32'(pix_x), 32'(total > 0 ? ng : 0));
    chk("update_pulses", 32'(upd_n), 32'(total > 0 ? ng : 0));
    chk("results_drained", 32'(exp_q.size()), 32'd0);
    if (lat_chk) begin
      chk("first_result_latency", 32'(rv0 - n0), 32'd4);
      chk("done_after_pop", 32'(done_c - rv0), 32'd2);
    end
    if (total == 0) chk("zero_job_done_latency", 32'(done_c >= 1 && done_c <= 2), 32'd1);
    if (rmode == 2 && total == 8) begin
      chk("bp_stall_seen", 32'(stall_seen), 32'd1);
`ifdef MAC_CTRL_STALL_CNT_EN
      chk("stall_count_nonzero", 32'(stall_cycles != 16'd0), 32'd1);
`else
      chk("stall_count_tied_zero", 32'(stall_cycles), 32'd0);
`endif
    end
    @(negedge clk);
    chk("done_single_cycle", 32'({done, busy}), 32'd0);
    wgt_valid = 1'b0; pix_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; num_groups = 8'd2; wgt_per_pix = 8'd2;
    pix_in = '0; wgt_in = '0; pix_valid = 1'b1; wgt_valid = 1'b1; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        32'({busy, done, res_valid, mac_enable, wgt_ready, pix_ready, mac_update_inputs}), 32'd0);
    chk("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    start = 1'b0; pix_valid = 1'b0; wgt_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'({busy, done, res_valid}), 32'd0);

    run_job(1, 1, 0, 0, 0, 1'b1);
    run_job(2, 3, 0, 0, 0, 1'b0);
    run_job(1, 8, 0, 2, 0, 1'b0);
    run_job(3, 2, 1, 0, 0, 1'b0);
    run_job(0, 5, 0, 0, 0, 1'b0);
    run_job(4, 0, 0, 0, 0, 1'b0);
    run_job(2, 4, 0, 2, 20, 1'b0);
    chk("post_abort_idle", 32'({busy, res_valid, done}), 32'd0);
    run_job(2, 3, 0, 0, 0, 1'b0);
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(1, 3), $urandom_range(1, 4), 2, 1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
